// File: rtl/sram_arbiter.sv
// Two-requester arbiter and access sequencer for a single asynchronous SRAM port.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise cpu has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              sram_drive,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                gnt_q, gnt_d;       // 0 = cpu, 1 = aux
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;
  logic                aux_wins;

`ifdef SRAM_ARB_RR_EN
  logic                last_q, last_d;     // grant id of the previous transaction

  always_comb begin
    aux_wins = aux_req && (!cpu_req || !last_q);
  end
`else
  always_comb begin
    aux_wins = aux_req && !cpu_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_d       = gnt_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req || aux_req) begin
          gnt_d   = aux_wins;
          addr_d  = aux_wins ? aux_addr  : cpu_addr;
          wdata_d = aux_wins ? aux_wdata : cpu_wdata;
          we_d    = aux_wins ? aux_we    : cpu_we;
          cnt_d   = 4'd0;
          state_d = ACCESS;
`ifdef SRAM_ARB_RR_EN
          last_d  = aux_wins;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          // Data is sampled at the end of the strobe, after the full access time.
          if (!we_q) begin
            if (gnt_q) aux_rdata_d = Data_from_SRAM;
            else       cpu_rdata_d = Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_q       <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Pins decode from registered state only, never from the request inputs.
  always_comb begin
    Mem_CE       = (state_q != ACCESS);
    Mem_UB       = (state_q != ACCESS);
    Mem_LB       = (state_q != ACCESS);
    Mem_OE       = !((state_q == ACCESS) && !we_q);
    Mem_WE       = !((state_q == ACCESS) && we_q);
    sram_drive   = (state_q == ACCESS) && we_q;
    ADDR         = addr_q;
    Data_to_SRAM = wdata_q;
    busy         = (state_q != IDLE);
    cpu_ack      = (state_q == DONE) && !gnt_q;
    aux_ack      = (state_q == DONE) && gnt_q;
    cpu_rdata    = cpu_rdata_q;
    aux_rdata    = aux_rdata_q;
  end

endmodule
